// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via shift-and-subtract,
// driven by a start/done handshake, with a one-cycle divide-by-zero shortcut.
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Shifted partial remainder keeps its carry-out bit: 2R+1 can exceed WIDTH bits.
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_sh;

  always_comb begin
    r_sh    = {r_q, q_q[WIDTH-1]};
    q_sh    = {q_q[WIDTH-2:0], 1'b0};
    diff    = r_sh - {1'b0, dvs_q};
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = divisor;
          q_d   = dividend;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!diff[WIDTH]) begin
          r_d = diff[WIDTH-1:0];
          q_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          r_d = r_sh[WIDTH-1:0];
          q_d = q_sh;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Bench for seq_divider16: scenario tasks plus a done-triggered scoreboard holding
// {div_by_zero, quotient, remainder} expectations.
module tb_seq_divider16;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [2*W:0] exp_q[$];

  seq_divider16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [2*W:0] exp_v;
      logic [2*W:0] got_v;
      done_cnt++;
      checks++;
      got_v = {div_by_zero, quotient, remainder};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done got dbz=%0b q=%0d r=%0d with no pending request",
                 div_by_zero, quotient, remainder);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL sb_result got dbz=%0b q=%0d r=%0d expected dbz=%0b q=%0d r=%0d",
                   got_v[2*W], got_v[2*W-1:W], got_v[W-1:0],
                   exp_v[2*W], exp_v[2*W-1:W], exp_v[W-1:0]);
        end
      end
    end
  end

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  // Driver: call at a negedge; returns at the negedge after the accepting edge.
  task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wait_done_timeout got done=0 after %0d cycles required done within 40", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #3;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    issue_op(16'd100, 16'd7, 1'b1);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 17) begin
      failures++;
      $display("FAIL basic_latency got done at cycle %0d required 17", cyc);
    end
    checks++;
    if (bcnt !== 16) begin
      failures++;
      $display("FAIL basic_busy_cycles got %0d required 16", bcnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%0b one cycle later required 0", done);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcnt;
    int dc0;
    issue_op(16'd100, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    dc0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      failures++;
      $display("FAIL reset_mid_run got busy=%0b done=%0b q=%0d r=%0d dbz=%0b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== dc0) begin
      failures++;
      $display("FAIL reset_no_done got %0d done pulses after abort required 0", done_cnt - dc0);
    end
    issue_op(16'd100, 16'd7, 1'b1);
    wait_done(cyc, bcnt);
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    int cyc, bcnt;
    logic [W-1:0] tbl_a[4] = '{16'd18, 16'd2, 16'hFFFF, 16'hFFFF};
    logic [W-1:0] tbl_b[4] = '{16'd18, 16'd3, 16'd1,   16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      issue_op(tbl_a[i], tbl_b[i], 1'b1);
      wait_done(cyc, bcnt);
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    int cyc, bcnt;
    issue_op(16'd5, 16'd0, 1'b1);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 1 || bcnt !== 0) begin
      failures++;
      $display("FAIL dbz_latency got cycle=%0d busy_cycles=%0d required cycle=1 busy_cycles=0",
               cyc, bcnt);
    end
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_held got div_by_zero=%0b after done required 1", div_by_zero);
    end
    issue_op(16'd9, 16'd2, 1'b1);
    checks++;
    if (div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dbz_clear got div_by_zero=%0b after new start required 0", div_by_zero);
    end
    wait_done(cyc, bcnt);
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int cyc, bcnt;
    int dc0;
    dc0 = done_cnt;
    issue_op(16'd100, 16'd7, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      dividend = W'($urandom_range(0, 16'hFFFF));
      divisor  = W'($urandom_range(0, 16'hFFFF));
      @(negedge clk);
    end
    wait_done(cyc, bcnt);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt - dc0 !== 1) begin
      failures++;
      $display("FAIL ignore_start_pulses got %0d done pulses required 1", done_cnt - dc0);
    end
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL ignore_start_hold got q=%0d r=%0d required q=14 r=2", quotient, remainder);
    end
  endtask

  task automatic test_random();
    int cyc, bcnt;
    for (int i = 0; i < 6; i++) begin
      issue_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(1, 16'hFFFF >> (i * 2))), 1'b1);
      wait_done(cyc, bcnt);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_boundaries();
    test_div_by_zero();
    test_ignore_start();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending results required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
